change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Downstream stage of the coffee vending controller. Consumes the machine's 4-bit change/refund value and pays it out as physical coins through a three-tube coin hopper using a req/ack handshake. Selects denominations greedily, tracks per-tube inventory and reports shortfall and hopper faults to the top level.

Parameters:
CNT_W, 6, width of each tube inventory counter (saturating).
ACK_TIMEOUT, 15, max cycles eject_req may wait for eject_ack before FAULT.
EJ_GAP, 2, idle cycles between successive ejections (min 1).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
change_in  input  4  change amount from controller; nonzero for one cycle is a payout request
refill_valid  input  1  one-cycle tube refill strobe
refill_sel  input  2  tube to refill: 01=1-unit, 10=2-unit, 11=3-unit (00 ignored)
refill_count  input  CNT_W  coins added to selected tube
fault_clr  input  1  clears FAULT state
eject_ack  input  1  hopper confirms one coin ejected
eject_req  output  1  request hopper to eject one coin
eject_sel  output  2  tube to eject from, same coding as refill_sel
busy  output  1  payout in progress (state not IDLE)
done  output  1  one-cycle pulse: full amount paid
short  output  1  one-cycle pulse: payout ended unpaid
owed  output  4  unpaid remainder latched at last short; cleared on next accepted request
fault  output  1  high while in FAULT
cnt1, cnt2, cnt3  output  CNT_W each  current tube inventories

Behaviour:
- Reset: all outputs 0; state IDLE; remaining=0, pending=0, tube counts=0.
- Request capture: change_in!=0 in IDLE -> remaining<=change_in, owed<=0, go SELECT next cycle. change_in!=0 while not IDLE -> pending<=min(pending+change_in,15). On entry to IDLE with pending!=0 -> load pending as new request, pending<=0 (takes priority over a same-cycle change_in, which is added to pending).
- SELECT (1 cycle): pick largest d in {3,2,1} with d<=remaining and tube count>0. Found -> EJECT with eject_sel latched. remaining==0 -> pulse done, IDLE. Nothing fits -> owed<=remaining, pulse short, remaining<=0, IDLE.
- EJECT: eject_req=1, eject_sel stable until ack. eject_ack with req high -> remaining-=d, tube count-=1, go GAP. ack with req low ignored. Wait counter reaching ACK_TIMEOUT with no ack -> FAULT.
- GAP: EJ_GAP cycles, eject_req=0, then SELECT.
- FAULT: eject_req=0, fault=1, remaining and pending held; fault_clr -> SELECT (resume). change_in still accumulates into pending.
- Refill: tube += refill_count saturating at 2^CNT_W-1, in any state. Same-cycle refill and ack on one tube: net count = old + refill_count - 1 (saturate after).
- Latency: change_in cycle N -> eject_req at N+2 when stock exists.
- Reset mid-eject: eject_req drops immediately (async), request lost.

Optional Feature:
CHANGE_STATS_EN: when defined, adds outputs paid_total (16-bit, wraps) incremented by d on every accepted ack, and short_events (8-bit, saturating) incremented on each short pulse; both reset to 0. When undefined, ports and logic are absent; all other behaviour identical.

Decomposition:
- Shared package: coin/tube code constants (COIN_NONE=00, COIN_1=01, COIN_2=10, COIN_3=11), coin value decode function, state encoding (IDLE, SELECT, EJECT, GAP, FAULT), shared with the controller's coin decode.
- Sub-module coin_tube_counter (one per tube): saturating inventory counter with refill-add/eject-decrement port.

Test Plan:
- Refill tubes 3/2/1 with 5 each; change_in=8 -> ejects 3,3,2 in order, done pulse, cnt3=3, cnt2=4, cnt1=5.
- Only tube1 stocked with 2; change_in=5 -> two 1-unit ejects, short pulse, owed=3, busy falls.
- change_in=4 then change_in=3 during payout -> first pays 3+1, then pending 3 pays as one 3-unit coin, two done pulses.
- Hold eject_ack low 15 cycles -> fault=1, eject_req=0; fault_clr -> resumes same eject_sel, completes payout.
- Refill tube2 +1 on same cycle as tube2 ack with cnt2=4 -> cnt2 stays 4; refill to saturation -> clamps at 63.
- Assert reset_n low mid-EJECT -> eject_req, busy, counts immediately 0; after release change_in=0 causes no activity.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: coin/tube codes, coin value decode and dispenser state encoding
package change_dispenser_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1 = 2'b01;
  localparam logic [1:0] COIN_2 = 2'b10;
  localparam logic [1:0] COIN_3 = 2'b11;
  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FAULT} state_t;
  function automatic logic [3:0] coin_value(input logic [1:0] c);
    return {2'b00, c};
  endfunction
endpackage

// File: rtl/coin_tube_counter.sv
// coin_tube_counter: saturating tube inventory with refill-add and eject-decrement
module coin_tube_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             add_en,
  input  logic [CNT_W-1:0] add_val,
  input  logic             dec_en,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W:0] nxt;
  assign nxt = {1'b0, cnt} + (add_en ? {1'b0, add_val} : '0) - {{CNT_W{1'b0}}, dec_en && cnt != '0};
  // refill and eject net out in one step, then clamp at full scale
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= nxt[CNT_W] ? '1 : nxt[CNT_W-1:0];
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout over a 3-tube hopper; CHANGE_STATS_EN adds payout statistics
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int ACK_TIMEOUT = 15,
  parameter int EJ_GAP = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       change_in,
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  input  logic [CNT_W-1:0] refill_count,
  input  logic             fault_clr,
  input  logic             eject_ack,
  output logic             eject_req,
  output logic [1:0]       eject_sel,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [3:0]       owed,
  output logic             fault,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`ifdef CHANGE_STATS_EN
  ,
  output logic [15:0]      paid_total,
  output logic [7:0]       short_events
`endif
);
  localparam int WW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(EJ_GAP + 1);
  state_t state, state_nx;
  logic [3:0] remaining, pending;
  logic [4:0] pend_sum;
  logic [1:0] sel, pick;
  logic [WW-1:0] wait_cnt;
  logic [GW-1:0] gap_cnt;
  logic [CNT_W-1:0] cnts [3];
  logic ack_ok, wait_last, gap_last;
  for (genvar t = 0; t < 3; t++) begin : g_tube
    coin_tube_counter #(.CNT_W(CNT_W)) u_tube (
      .clk(clk), .reset_n(reset_n),
      .add_en(refill_valid && refill_sel == 2'(t + 1)), .add_val(refill_count),
      .dec_en(ack_ok && sel == 2'(t + 1)), .cnt(cnts[t])
    );
  end
  assign {cnt1, cnt2, cnt3} = {cnts[0], cnts[1], cnts[2]};
  assign ack_ok = state == EJECT && eject_ack;
  assign wait_last = wait_cnt == WW'(ACK_TIMEOUT - 1);
  assign gap_last = gap_cnt == GW'(EJ_GAP - 1);
  assign pend_sum = pending + change_in;
  assign pick = (remaining >= 4'd3 && cnts[2] != '0) ? COIN_3 :
                (remaining >= 4'd2 && cnts[1] != '0) ? COIN_2 :
                (remaining != 4'd0 && cnts[0] != '0) ? COIN_1 : COIN_NONE;
  assign eject_req = state == EJECT;
  assign eject_sel = eject_req ? sel : COIN_NONE;
  assign busy = state != IDLE;
  assign fault = state == FAULT;
  // next-state: greedy select, handshake with timeout, inter-coin gap, fault hold
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (pending != 0 || change_in != 0) ? SELECT : IDLE;
      SELECT:  state_nx = (pick != COIN_NONE) ? EJECT : IDLE;
      EJECT:   state_nx = eject_ack ? GAP : wait_last ? FAULT : EJECT;
      GAP:     state_nx = gap_last ? SELECT : GAP;
      FAULT:   state_nx = fault_clr ? SELECT : FAULT;
      default: state_nx = IDLE;
    endcase
  end
  // state, amounts, coin choice, timers and result pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      remaining <= '0;
      pending <= '0;
      sel <= COIN_NONE;
      wait_cnt <= '0;
      gap_cnt <= '0;
      owed <= '0;
      done <= 1'b0;
      short <= 1'b0;
    end else begin
      state <= state_nx;
      done <= state == SELECT && remaining == 0;
      short <= state == SELECT && remaining != 0 && pick == COIN_NONE;
      wait_cnt <= (state == EJECT) ? wait_cnt + 1'b1 : '0;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == IDLE && pending != 0) begin
        remaining <= pending;
        pending <= change_in;
        owed <= '0;
      end else if (state == IDLE && change_in != 0) begin
        remaining <= change_in;
        owed <= '0;
      end else if (change_in != 0) pending <= pend_sum[4] ? 4'hf : pend_sum[3:0];
      if (state == SELECT) begin
        sel <= pick;
        if (pick == COIN_NONE) begin
          remaining <= '0;
          if (remaining != 0) owed <= remaining;
        end
      end
      if (ack_ok) remaining <= remaining - coin_value(sel);
    end
`ifdef CHANGE_STATS_EN
  // running paid value (wrapping) and saturating count of shortfalls
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      paid_total <= '0;
      short_events <= '0;
    end else begin
      if (ack_ok) paid_total <= paid_total + 16'(coin_value(sel));
      if (short && short_events != 8'hff) short_events <= short_events + 8'd1;
    end
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser with directed payout scenarios
module tb_change_dispenser;
  localparam int K_EJ = 0, K_DONE = 1, K_SHORT = 2;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] change_in;
  logic refill_valid;
  logic [1:0] refill_sel;
  logic [5:0] refill_count;
  logic fault_clr, eject_ack;
  logic eject_req, busy, done, short, fault;
  logic [1:0] eject_sel;
  logic [3:0] owed;
  logic [5:0] cnt1, cnt2, cnt3;
  int n_chk = 0, n_fail = 0;
  int expq[$];
  bit ack_en = 1'b1;

  change_dispenser dut (
    .clk(clk), .reset_n(reset_n), .change_in(change_in), .refill_valid(refill_valid),
    .refill_sel(refill_sel), .refill_count(refill_count), .fault_clr(fault_clr),
    .eject_ack(eject_ack), .eject_req(eject_req), .eject_sel(eject_sel), .busy(busy),
    .done(done), .short(short), .owed(owed), .fault(fault),
    .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_evt(input int kind, input int val);
    int e;
    n_chk++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d value %0d expected none", kind, val);
    end else begin
      e = expq.pop_front();
      if (e != kind * 16 + val) begin
        n_fail++;
        $display("FAIL event: got kind %0d value %0d expected kind %0d value %0d", kind, val, e / 16, e % 16);
      end
    end
  endtask

  task automatic push(input int kind, input int val);
    expq.push_back(kind * 16 + val);
  endtask

  // monitor: new eject requests, done and short pulses go to the scoreboard
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (eject_req && !prev) expect_evt(K_EJ, int'(eject_sel));
      if (done) expect_evt(K_DONE, int'(owed));
      if (short) expect_evt(K_SHORT, int'(owed));
      prev = eject_req;
    end
  end

  // hopper: acknowledges a visible request on the following edge when enabled
  initial begin
    eject_ack = 1'b0;
    forever begin
      @(negedge clk);
      eject_ack = ack_en && eject_req;
    end
  end

  task automatic send(input logic [3:0] v);
    @(negedge clk);
    change_in = v;
    @(negedge clk);
    change_in = 4'd0;
  endtask

  task automatic refill(input logic [1:0] s, input logic [5:0] n);
    @(negedge clk);
    refill_valid = 1'b1;
    refill_sel = s;
    refill_count = n;
    @(negedge clk);
    refill_valid = 1'b0;
    refill_sel = 2'd0;
    refill_count = 6'd0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !busy) break;
    end
    check({name, "_pending_events"}, expq.size(), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    change_in = 4'd0; refill_valid = 1'b0; refill_sel = 2'd0; refill_count = 6'd0; fault_clr = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_eject_req", int'(eject_req), 0);
    check("rst_eject_sel", int'(eject_sel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_short", int'(short), 0);
    check("rst_owed", int'(owed), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_cnt", int'(cnt1) + int'(cnt2) + int'(cnt3), 0);
    reset_n = 1'b1;
    // greedy 8 = 3+3+2 with N+2 request latency
    refill(2'd3, 6'd5); refill(2'd2, 6'd5); refill(2'd1, 6'd5);
    check("refill_cnt3", int'(cnt3), 5);
    push(K_EJ, 3); push(K_EJ, 3); push(K_EJ, 2); push(K_DONE, 0);
    send(4'd8);
    check("lat_busy", int'(busy), 1);
    check("lat_req_n1", int'(eject_req), 0);
    @(negedge clk);
    check("lat_req_n2", int'(eject_req), 1);
    check("lat_sel", int'(eject_sel), 3);
    wait_idle("pay8");
    check("pay8_cnt3", int'(cnt3), 3);
    check("pay8_cnt2", int'(cnt2), 4);
    check("pay8_cnt1", int'(cnt1), 5);
    // shortfall: only two 1-unit coins for 5
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    refill(2'd1, 6'd2);
    push(K_EJ, 1); push(K_EJ, 1); push(K_SHORT, 3);
    send(4'd5);
    wait_idle("short5");
    check("short5_owed", int'(owed), 3);
    check("short5_cnt1", int'(cnt1), 0);
    // request during payout is queued as pending; owed cleared on accept
    refill(2'd3, 6'd5); refill(2'd1, 6'd5);
    push(K_EJ, 3); push(K_EJ, 1); push(K_DONE, 0); push(K_EJ, 3); push(K_DONE, 0);
    send(4'd4);
    repeat (2) @(negedge clk);
    send(4'd3);
    wait_idle("pend");
    check("pend_owed", int'(owed), 0);
    check("pend_cnt3", int'(cnt3), 3);
    check("pend_cnt1", int'(cnt1), 4);
    // ack timeout -> fault, change accumulates, clear resumes
    refill(2'd2, 6'd4);
    ack_en = 1'b0;
    push(K_EJ, 2);
    send(4'd2);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fault) break;
      if (eject_req) n++;
    end
    check("timeout_req_cycles", n, 15);
    check("fault_high", int'(fault), 1);
    check("fault_req_low", int'(eject_req), 0);
    send(4'd1);
    check("fault_hold", int'(fault), 1);
    push(K_EJ, 2); push(K_DONE, 0); push(K_EJ, 1); push(K_DONE, 0);
    ack_en = 1'b1;
    @(negedge clk); fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    wait_idle("fault");
    check("fault_cleared", int'(fault), 0);
    check("fault_cnt2", int'(cnt2), 3);
    check("fault_cnt1", int'(cnt1), 3);
    // refill and ack on tube 2 in the same cycle
    refill(2'd2, 6'd1);
    check("pre_same_cnt2", int'(cnt2), 4);
    push(K_EJ, 2); push(K_DONE, 0);
    @(negedge clk); change_in = 4'd2;
    @(negedge clk); change_in = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (eject_req) begin
        refill_valid = 1'b1; refill_sel = 2'd2; refill_count = 6'd1;
        break;
      end
    end
    @(negedge clk);
    refill_valid = 1'b0; refill_sel = 2'd0; refill_count = 6'd0;
    check("same_cycle_cnt2", int'(cnt2), 4);
    wait_idle("same");
    // saturation and ignored selector
    refill(2'd2, 6'd63);
    check("sat_cnt2", int'(cnt2), 63);
    refill(2'd0, 6'd5);
    check("sel0_cnt1", int'(cnt1), 3);
    check("sel0_cnt3", int'(cnt3), 3);
    // asynchronous reset during an ejection
    ack_en = 1'b0;
    push(K_EJ, 1);
    send(4'd1);
    @(negedge clk);
    check("pre_rst_req", int'(eject_req), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_req", int'(eject_req), 0);
    check("async_busy", int'(busy), 0);
    check("async_cnt1", int'(cnt1), 0);
    check("async_cnt2", int'(cnt2), 0);
    check("async_cnt3", int'(cnt3), 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_queue", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
